dc_video_tx: RTL and testbench
==============================

# dc_video_tx

Dreamcast-side digital video bus transmitter: generates the 12-bit multiplexed RGB bus plus active-low `_hsync`/`_vsync` in exactly the format the capture path consumes. Pixel colour comes from an upstream pixel source via a fixed-latency request interface. Used as the stimulus source for capture-path benches and as an on-chip loopback source. In IDLE it emulates a disconnected console, so the capture path's no-signal detection can be exercised.

## Interface
- `H_TOTAL`, 1716: clocks per line.
- `HSYNC_LEN`, 128: clocks `_hsync` is low per line.
- `VSYNC_LINES`, 6: lines `_vsync` is low per frame.
- `H_ACTIVE_START`, 250: hc of the first active clock. Must be even.
- `H_ACTIVE_PIX`, 720: pixels per active line. Each pixel takes 2 clocks.

- `clock`  in  1  bus clock (27 MHz in system).
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  level. High starts or keeps generation; low stops at the end of the current frame.
- `mode`  in  2  0 = 480 (525 lines), 1 = 240p (263 lines), 2 = PAL (625 lines), 3 = treated as 0. Latched only at frame start.
- `rgb_in`  in  24  {R,G,B} for the requested pixel. Valid in the cycle after `pix_req`.
- `pix_req`  out  1  one-cycle pixel request.
- `pix_x`  out  10  pixel column of the request, 0..719.
- `pix_y`  out  10  active line of the request.
- `data`  out  12  multiplexed video bus.
- `_hsync`  out  1  active-low horizontal sync.
- `_vsync`  out  1  active-low vertical sync.
- `frame_start`  out  1  one-cycle pulse at hc = 0, vc = 0 of every generated frame.
- `frame_count`  out  16  number of completed frames. Wraps.
- `busy`  out  1  high in RUN and STOP.

## Operation
- Counters: hc runs 0..H_TOTAL-1 and vc runs 0..V_TOTAL-1.
  - hc wraps to 0 and increments vc.
  - vc wraps to 0 at V_TOTAL-1.
- Per-mode values (V_TOTAL / V_ACTIVE / V_START):
  - mode 0: 525 / 480 / 36.
  - mode 1: 263 / 240 / 18.
  - mode 2: 625 / 576 / 44.
- Syncs:
  - `_hsync` = 0 iff hc < HSYNC_LEN.
  - `_vsync` = 0 iff vc < VSYNC_LINES.
  - Both fall in the same cycle at hc = 0, vc = 0. `_vsync` changes only at hc = 0.
- Active region: vc in [V_START, V_START+V_ACTIVE) and hc in [H_ACTIVE_START, H_ACTIVE_START+1440).
- Pixel k of active line y = vc-V_START:
  - hc = H_ACTIVE_START+2k: `data` = {R[7:0], G[7:4]}.
  - hc = H_ACTIVE_START+2k+1: `data` = {G[3:0], B[7:0]}.
- Outside the active region in RUN/STOP, `data` = 12'h000.
- Pixel fetch:
  - `pix_req` is high for exactly one cycle at hc = H_ACTIVE_START+2k-2, with `pix_x` = k and `pix_y` = y.
  - `rgb_in` is captured at the end of the following cycle.
  - `pix_x`/`pix_y` hold their last value when `pix_req` = 0.
- FSM states IDLE, RUN, STOP:
  - IDLE: `data` = 12'hFFF, `_hsync` = `_vsync` = 1, hc = vc = 0. Counters frozen.
  - IDLE→RUN: when `enable` = 1 is sampled. `mode` is latched. The next cycle is hc = 0, vc = 0: `frame_start` = 1 and both syncs are low.
  - RUN→STOP: when `enable` = 0 is sampled.
  - STOP→RUN: when `enable` = 1 is sampled again. No frame restart.
  - Frame end is the cycle with hc = H_TOTAL-1 and vc = V_TOTAL-1. At frame end, `frame_count` increments.
  - Frame end in RUN: `mode` is re-latched.
  - Frame end in STOP: go to IDLE. A frame is never truncated.
- A mode change mid-frame has no effect until the next frame start.

## Timing
- All outputs are registered.
- Reset values: `data` = 12'hFFF, `_hsync` = 1, `_vsync` = 1, `pix_req` = 0, `pix_x` = 0, `pix_y` = 0, `frame_start` = 0, `frame_count` = 0, `busy` = 0. State IDLE.
- Reset mid-frame: all outputs take their reset values immediately (asynchronously). No partial line completes.
- Latency: `pix_req` to the first half on `data` is 2 cycles; to the second half is 3 cycles.
- The capture side resets its raw X counter on the `_hsync` falling edge, so its raw X = hc-1. First halves therefore land on its odd raw X.
- Line period is H_TOTAL clocks. Frame period is H_TOTAL×V_TOTAL clocks; for mode 0 that is 900 900 clocks.
- Simultaneous `enable` fall at frame end in RUN: the frame completes, the state goes to STOP, and the next full frame is generated before IDLE.

## Test plan
- Reset, then `enable` = 1 with mode 0. Require:
  - `_hsync` low for 128 clocks every 1716 clocks.
  - `_vsync` low for 6 lines.
  - vsync falls together with hsync.
  - 525 lines per frame.
- Drive `rgb_in` = {8'hA5, 8'h3C, 8'h96} constantly. Require `data` alternates 12'hA53, 12'hC96 across hc 250..1689 on active lines, and is 12'h000 elsewhere.
- Return `rgb_in` = {pix_y[7:0], pix_x[7:0], 8'h00} one cycle after `pix_req`.
  - Require pixel (5, 7) appears at vc = 43, hc = 260/261 as 12'h070, 12'h500.
  - Require exactly 720 `pix_req` pulses per active line.
- Switch `mode` to 1 mid-frame. Require the current frame stays at 525 lines, the next frame is 263 lines, and vsync period becomes 263×1716.
- Drop `enable` mid-frame. Require the frame completes, `frame_count` increments by 1, then IDLE: `data` = 12'hFFF, syncs high, `busy` = 0.
- Assert `reset` at vc = 100. Require all outputs go to reset values immediately. After release with `enable` = 1, a fresh frame starts with `frame_start` = 1.

Source files
------------

// File: rtl/dc_video_tx.sv
// Dreamcast-side digital video bus transmitter: sync/timing generator that serialises
// upstream RGB pixels onto the 12-bit multiplexed bus, with an IDLE "disconnected" state.
module dc_video_tx #(
    parameter int unsigned H_TOTAL        = 1716,
    parameter int unsigned HSYNC_LEN      = 128,
    parameter int unsigned VSYNC_LINES    = 6,
    parameter int unsigned H_ACTIVE_START = 250,
    parameter int unsigned H_ACTIVE_PIX   = 720
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [23:0] rgb_in,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] data,
    output logic        _hsync,
    output logic        _vsync,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        busy
);
    localparam int unsigned   HW          = $clog2(H_TOTAL);
    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam int unsigned   FETCH_START = H_ACTIVE_START - 2;
    localparam int unsigned   ACTIVE_END  = H_ACTIVE_START + 2 * H_ACTIVE_PIX;

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hc_q, hc_d;
    logic [9:0]    vc_q, vc_d;
    logic [1:0]    mode_q, mode_d;
    logic [11:0]   lo_q;
    logic [9:0]    v_total_cur, v_start_d, v_active_d, fetch_x;
    logic          frame_end, live_d, row_d, fetch_d, show_d;
    int unsigned   hc_n;

    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? 2'd0 : m;
    endfunction

    function automatic logic [9:0] v_total_of(input logic [1:0] m);
        case (m)
            2'd1:    return 10'd263;
            2'd2:    return 10'd625;
            default: return 10'd525;
        endcase
    endfunction

    function automatic logic [9:0] v_start_of(input logic [1:0] m);
        case (m)
            2'd1:    return 10'd18;
            2'd2:    return 10'd44;
            default: return 10'd36;
        endcase
    endfunction

    function automatic logic [9:0] v_active_of(input logic [1:0] m);
        case (m)
            2'd1:    return 10'd240;
            2'd2:    return 10'd576;
            default: return 10'd480;
        endcase
    endfunction

    always_comb begin
        v_total_cur = v_total_of(mode_q);
        frame_end   = (state_q != StIdle) && (hc_q == H_LAST) &&
                      (vc_q == v_total_cur - 10'd1);
        state_d = state_q;
        hc_d    = hc_q;
        vc_d    = vc_q;
        mode_d  = mode_q;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StRun;
                    mode_d  = norm_mode(mode);
                end
            end
            default: begin
                if (frame_end) begin
                    hc_d = '0;
                    vc_d = '0;
                    // A STOP frame only ends in IDLE if enable is still low at its last clock
                    if (state_q == StRun || enable) begin
                        state_d = enable ? StRun : StStop;
                        mode_d  = norm_mode(mode);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    state_d = enable ? StRun : StStop;
                    if (hc_q == H_LAST) begin
                        hc_d = '0;
                        vc_d = vc_q + 10'd1;
                    end else begin
                        hc_d = hc_q + 1'b1;
                    end
                end
            end
        endcase

        // Outputs are registered from the position being entered next cycle
        live_d     = (state_d != StIdle);
        hc_n       = 32'(hc_d);
        v_start_d  = v_start_of(mode_d);
        v_active_d = v_active_of(mode_d);
        row_d      = (vc_d >= v_start_d) && (vc_d < v_start_d + v_active_d);
        fetch_d    = row_d && (hc_n >= FETCH_START) && (hc_n < ACTIVE_END - 2) && !hc_d[0];
        show_d     = row_d && (hc_n >= H_ACTIVE_START) && (hc_n < ACTIVE_END);
        fetch_x    = 10'((hc_n - FETCH_START) >> 1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            hc_q        <= '0;
            vc_q        <= '0;
            mode_q      <= 2'd0;
            lo_q        <= 12'h000;
            pix_req     <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            data        <= 12'hFFF;
            _hsync      <= 1'b1;
            _vsync      <= 1'b1;
            frame_start <= 1'b0;
            frame_count <= 16'd0;
            busy        <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            mode_q  <= mode_d;
            busy    <= live_d;
            pix_req <= live_d && fetch_d;
            if (frame_end) begin
                frame_count <= frame_count + 16'd1;
            end
            if (live_d && fetch_d) begin
                pix_x <= fetch_x;
                pix_y <= vc_d - v_start_d;
            end
            if (!live_d) begin
                data        <= 12'hFFF;
                _hsync      <= 1'b1;
                _vsync      <= 1'b1;
                frame_start <= 1'b0;
            end else begin
                _hsync      <= !(hc_n < HSYNC_LEN);
                _vsync      <= !(32'(vc_d) < VSYNC_LINES);
                frame_start <= (hc_d == '0) && (vc_d == '0);
                if (!show_d) begin
                    data <= 12'h000;
                end else if (!hc_d[0]) begin
                    // First half comes straight from rgb_in; keep the rest for the odd clock
                    data <= {rgb_in[23:16], rgb_in[15:12]};
                    lo_q <= rgb_in[11:0];
                end else begin
                    data <= lo_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_dc_video_tx.sv
// Randomized bench for dc_video_tx on a shortened line; expected outputs come from a
// frame-time model (cycle index within frame -> position -> sync/pixel values).
module tb_dc_video_tx;
    localparam int H   = 32;
    localparam int HS  = 4;
    localparam int VS  = 6;
    localparam int HAS = 8;
    localparam int P   = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [23:0] rgb_in;
    logic        pix_req;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] data;
    logic        hsync_n, vsync_n, frame_start, busy;
    logic [15:0] frame_count;

    dc_video_tx #(
        .H_TOTAL(H), .HSYNC_LEN(HS), .VSYNC_LINES(VS), .H_ACTIVE_START(HAS), .H_ACTIVE_PIX(P)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .rgb_in(rgb_in),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .data(data),
        ._hsync(hsync_n), ._vsync(vsync_n), .frame_start(frame_start),
        .frame_count(frame_count), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_fail = 0, cyc = 0;

    // Model state: 0 idle, 1 run, 2 stop; m_t is the clock index within the frame
    int          m_st, m_t, m_mode, m_frame = 0, m_pat = 0;
    logic [31:0] m_seed = 32'd0;
    logic [15:0] m_fc;
    logic [9:0]  m_x, m_y;
    logic [11:0] e_data;
    logic        e_hs, e_vs, e_req, e_fs, e_busy;

    logic        req_prev;
    logic [9:0]  x_prev, y_prev;
    int hs_cnt = 0, vs_cnt = 0, rq_cnt = 0, vs_bad = 0;
    logic prev_vs = 1'b1, prev_busy = 1'b0;
    int fs_q[$], bf_q[$], hs_q[$], vs_q[$], rq_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int vtot(input int m);
        return (m == 1) ? 263 : (m == 2) ? 625 : 525;
    endfunction
    function automatic int vstart(input int m);
        return (m == 1) ? 18 : (m == 2) ? 44 : 36;
    endfunction
    function automatic int vact(input int m);
        return (m == 1) ? 240 : (m == 2) ? 576 : 480;
    endfunction

    function automatic logic [23:0] pat_rgb(input int pat, input logic [31:0] seed,
                                            input int x, input int y);
        logic [31:0] h;
        if (pat == 0) return 24'hA53C96;
        if (pat == 1) return {y[7:0], x[7:0], 8'h00};
        h = (32'(x) * 32'h9E3779B1) ^ (32'(y) * 32'h85EBCA77) ^ seed;
        return h[23:0];
    endfunction

    task automatic new_frame();
        m_frame++;
        m_pat  = (m_frame == 1) ? 1 : (m_frame == 2) ? 0 : 2;
        m_seed = $urandom;
    endtask

    task automatic model_reset();
        m_st = 0; m_t = 0; m_mode = 0; m_fc = 16'd0; m_x = 10'd0; m_y = 10'd0;
        e_data = 12'hFFF; e_hs = 1'b1; e_vs = 1'b1; e_req = 1'b0; e_fs = 1'b0; e_busy = 1'b0;
        req_prev = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [1:0] md);
        int hc, vc, y0;
        logic [23:0] rgb;
        if (m_st == 0) begin
            if (en) begin m_st = 1; m_t = 0; m_mode = (md == 2'd3) ? 0 : int'(md); new_frame(); end
        end else if (m_t == H * vtot(m_mode) - 1) begin
            m_fc = m_fc + 16'd1;
            m_t  = 0;
            if (m_st == 1 || en) begin
                m_st = en ? 1 : 2; m_mode = (md == 2'd3) ? 0 : int'(md); new_frame();
            end else begin
                m_st = 0;
            end
        end else begin
            m_t++;
            m_st = en ? 1 : 2;
        end
        if (m_st == 0) begin
            e_data = 12'hFFF; e_hs = 1'b1; e_vs = 1'b1; e_req = 1'b0; e_fs = 1'b0; e_busy = 1'b0;
        end else begin
            hc = m_t % H; vc = m_t / H; y0 = vc - vstart(m_mode);
            e_hs = (hc >= HS); e_vs = (vc >= VS); e_fs = (m_t == 0); e_busy = 1'b1;
            e_req = 1'b0; e_data = 12'h000;
            if (y0 >= 0 && y0 < vact(m_mode)) begin
                if (hc >= HAS - 2 && hc < HAS - 2 + 2 * P && hc % 2 == 0) begin
                    e_req = 1'b1; m_x = 10'((hc - HAS + 2) / 2); m_y = 10'(y0);
                end
                if (hc >= HAS && hc < HAS + 2 * P) begin
                    rgb    = pat_rgb(m_pat, m_seed, (hc - HAS) / 2, y0);
                    e_data = (hc % 2 == 0) ? {rgb[23:16], rgb[15:12]} : rgb[11:0];
                end
            end
        end
    endtask

    // Inputs for the coming edge must already be set when this is called
    task automatic tick();
        model_step(enable, mode);
        @(negedge clock);
        cyc++;
        if (n_fail < 40) begin
            check("data", 32'(data), 32'(e_data));
            check("hsync", 32'(hsync_n), 32'(e_hs));
            check("vsync", 32'(vsync_n), 32'(e_vs));
            check("pix_req", 32'(pix_req), 32'(e_req));
            check("pix_x", 32'(pix_x), 32'(m_x));
            check("pix_y", 32'(pix_y), 32'(m_y));
            check("frame_start", 32'(frame_start), 32'(e_fs));
            check("frame_count", 32'(frame_count), 32'(m_fc));
            check("busy", 32'(busy), 32'(e_busy));
        end
        if (m_frame == 1 && m_st != 0 && m_t == 43 * H + HAS + 10) check("px57_hi", 32'(data), 32'h070);
        if (m_frame == 1 && m_st != 0 && m_t == 43 * H + HAS + 11) check("px57_lo", 32'(data), 32'h500);
        if (frame_start) begin
            fs_q.push_back(cyc);
            if (fs_q.size() > 1) begin
                hs_q.push_back(hs_cnt); vs_q.push_back(vs_cnt); rq_q.push_back(rq_cnt);
            end
            hs_cnt = 0; vs_cnt = 0; rq_cnt = 0;
        end
        if (!hsync_n) hs_cnt++;
        if (!vsync_n) vs_cnt++;
        if (pix_req) rq_cnt++;
        if (prev_vs && !vsync_n && !(frame_start && !hsync_n)) vs_bad++;
        if (prev_busy && !busy) bf_q.push_back(cyc);
        prev_vs = vsync_n; prev_busy = busy;
        rgb_in = req_prev ? pat_rgb(m_pat, m_seed, int'(x_prev), int'(y_prev)) : 24'($urandom);
        req_prev = pix_req; x_prev = pix_x; y_prev = pix_y;
    endtask

    task automatic run_n(input int n, input bit rnd_mode);
        for (int i = 0; i < n; i++) begin
            if (rnd_mode) mode = 2'($urandom);
            tick();
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_data"}, 32'(data), 32'hFFF);
        check({pfx, "_hsync"}, 32'(hsync_n), 32'd1);
        check({pfx, "_vsync"}, 32'(vsync_n), 32'd1);
        check({pfx, "_req"}, 32'(pix_req), 32'd0);
        check({pfx, "_x"}, 32'(pix_x), 32'd0);
        check({pfx, "_y"}, 32'(pix_y), 32'd0);
        check({pfx, "_fs"}, 32'(frame_start), 32'd0);
        check({pfx, "_fc"}, 32'(frame_count), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int budget;
        reset = 1'b1; enable = 1'b0; mode = 2'd0; rgb_in = 24'd0;
        model_reset();
        repeat (3) @(negedge clock);
        check_reset_values("rst0");
        reset = 1'b0;
        run_n(5, 1);

        // F1: mode 0, coordinate pixels; mode 1 requested mid-frame for the next frame
        enable = 1'b1; mode = 2'd0; tick();
        run_n(5000, 1);
        mode = 2'd1; run_n(11799, 0);
        // F2: mode 1; enable falls exactly on its last clock
        tick();
        run_n(3000, 1);
        mode = 2'd3; run_n(5415, 0);
        enable = 1'b0; tick();
        // F3: full frame in STOP (mode 3 -> 525 lines), then IDLE
        run_n(16799, 1);
        tick();
        run_n(20, 1);
        check("idle3_data", 32'(data), 32'hFFF);
        check("idle3_busy", 32'(busy), 32'd0);
        check("idle3_fc", 32'(frame_count), 32'd3);

        // F4: mode 1, enable dropped mid-frame
        mode = 2'd1; enable = 1'b1; tick();
        run_n(1999, 1);
        check("fc_mid", 32'(frame_count), 32'd3);
        run_n(2001, 1);
        enable = 1'b0; run_n(4415, 1);
        tick();
        check("fc_drop", 32'(frame_count), 32'd4);
        check("idle4_data", 32'(data), 32'hFFF);
        check("idle4_sync", 32'({hsync_n, vsync_n}), 32'd3);
        check("idle4_busy", 32'(busy), 32'd0);
        run_n(10, 1);

        // F5: mode 2 with random STOP/RUN toggling, reset hit at vc = 100
        mode = 2'd2; enable = 1'b1; tick();
        budget = 5000;
        while (!(m_st != 0 && m_t >= 100 * H + 10) && budget > 0) begin
            enable = ($urandom_range(0, 5) != 0);
            mode   = 2'($urandom);
            tick();
            budget--;
        end
        check("reach_vc100", 32'(budget > 0), 32'd1);
        #2 reset = 1'b1;
        #1 check_reset_values("rst_async");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        mode = 2'd0; enable = 1'b1; tick();
        check("fs_after_rst", 32'(frame_start), 32'd1);
        check("fc_after_rst", 32'(frame_count), 32'd0);
        run_n(2000, 1);

        check("n_frames", 32'(fs_q.size()), 32'd6);
        if (fs_q.size() == 6 && bf_q.size() >= 2 && hs_q.size() >= 3) begin
            check("f1_len", 32'(fs_q[1] - fs_q[0]), 32'(525 * H));
            check("f2_len", 32'(fs_q[2] - fs_q[1]), 32'(263 * H));
            check("f3_len", 32'(bf_q[0] - fs_q[2]), 32'(525 * H));
            check("f4_len", 32'(bf_q[1] - fs_q[3]), 32'(263 * H));
            check("f1_hs_low", 32'(hs_q[0]), 32'(525 * HS));
            check("f1_vs_low", 32'(vs_q[0]), 32'(VS * H));
            check("f1_reqs", 32'(rq_q[0]), 32'(480 * P));
            check("f2_hs_low", 32'(hs_q[1]), 32'(263 * HS));
            check("f2_vs_low", 32'(vs_q[1]), 32'(VS * H));
            check("f2_reqs", 32'(rq_q[1]), 32'(240 * P));
            check("f3_reqs", 32'(rq_q[2]), 32'(480 * P));
        end
        check("vs_fall_align", 32'(vs_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
